// File: rtl/vram_term_writer_if.sv
// ---------------------------------------------------------------------------
// vram_term_writer_if
// Groups the byte-stream handshake, the video-RAM write/read port and the
// cursor/status outputs of the character-terminal writer.
//
// Signals:
//   in_valid   host -> writer  byte on in_data is valid
//   in_data    host -> writer  character or control byte
//   in_ready   writer -> host  byte is accepted when in_valid && in_ready
//   vram_addr  writer -> RAM   {row[3:0], col[5:0]}
//   vram_din   writer -> RAM   write data
//   vram_we    writer -> RAM   write strobe
//   vram_dout  RAM -> writer   read data, one clk after the address
//   cursor_col writer -> host  current cursor column
//   cursor_row writer -> host  current cursor row
//   busy       writer -> host  clear or scroll in progress
//
// Modports:
//   master  the host/RAM side (drives the byte stream and the RAM read data)
//   slave   the writer itself
// ---------------------------------------------------------------------------
interface vram_term_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [9:0] vram_addr;
  logic [7:0] vram_din;
  logic       vram_we;
  logic [7:0] vram_dout;
  logic [5:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;

  modport master (
    output in_valid, in_data, vram_dout,
    input  in_ready, vram_addr, vram_din, vram_we, cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_valid, in_data, vram_dout,
    output in_ready, vram_addr, vram_din, vram_we, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/vram_term_writer.sv
// ---------------------------------------------------------------------------
// vram_term_writer
// Character-terminal writer for a 64x16 text video RAM (1 KB). Bytes arrive
// over a valid/ready handshake and are written at a hardware cursor. Handles
// carriage return (newline), backspace, clear screen and end-of-screen
// scrolling. Drives the write side of the RAM; RAM address is {row, col}.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    vram_term_writer_if.slave (handshake, RAM port, cursor, busy)
//
// Build option:
//   VRAM_TERM_SCROLL_EN  defined   : newline at row 15 scrolls rows 1..15
//                                    up by one and blanks row 15.
//                        undefined : newline at row 15 wraps to row 0 and
//                                    blanks row 0 (no scroll states).
// ---------------------------------------------------------------------------
module vram_term_writer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [7:0] CLR_CHAR   = 8'h0C,
  parameter logic [7:0] CR_CHAR    = 8'h0D,
  parameter logic [7:0] BS_CHAR    = 8'h08
) (
  input logic               clk,
  input logic               reset,
  vram_term_writer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUT       = 3'd1,
`ifdef VRAM_TERM_SCROLL_EN
    SCROLL_RD = 3'd2,
    SCROLL_WR = 3'd3,
`endif
    FILL_ROW  = 3'd4,
    CLEAR_ALL = 3'd5
  } state_t;

  state_t     state_reg;
  logic       in_ready_reg;
  logic [9:0] addr_reg;
  logic [7:0] din_reg;
  logic       we_reg;
  logic [5:0] col_reg;
  logic [3:0] row_reg;
  logic       busy_reg;
  logic       put_adv_reg;   // PUT advances the cursor (0 for backspace blank)

  logic accept;
  assign accept = bus.in_valid && in_ready_reg;

  // Next values for the newline path (column handling is done by the caller).
  // Shared by CR in IDLE and by the column-63 wrap in PUT.
  state_t     nl_state;
  logic [3:0] nl_row;
  logic [9:0] nl_addr;
  logic       nl_we;
  logic [7:0] nl_din;
  logic       nl_busy;

  always_comb begin
    nl_state = IDLE;
    nl_row   = row_reg + 4'd1;
    nl_addr  = addr_reg;
    nl_we    = 1'b0;
    nl_din   = din_reg;
    nl_busy  = 1'b0;
    if (row_reg == 4'd15) begin
`ifdef VRAM_TERM_SCROLL_EN
      // Scroll: first read source is the start of row 1; cursor stays on row 15.
      nl_state = SCROLL_RD;
      nl_row   = row_reg;
      nl_addr  = 10'd64;
      nl_we    = 1'b0;
      nl_busy  = 1'b1;
`else
      // Wrap to the top and blank the destination row.
      nl_state = FILL_ROW;
      nl_row   = 4'd0;
      nl_addr  = 10'd0;
      nl_we    = 1'b1;
      nl_din   = BLANK_CHAR;
      nl_busy  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b0;
      addr_reg     <= 10'd0;
      din_reg      <= 8'd0;
      we_reg       <= 1'b0;
      col_reg      <= 6'd0;
      row_reg      <= 4'd0;
      busy_reg     <= 1'b0;
      put_adv_reg  <= 1'b0;
    end else begin
      // Ready is a one-cycle-late image of IDLE, dropped on the accepting edge
      // so that a second byte can never be taken while leaving IDLE.
      in_ready_reg <= (state_reg == IDLE) && !accept;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.in_data == CLR_CHAR) begin
              state_reg <= CLEAR_ALL;
              addr_reg  <= 10'd0;
              din_reg   <= BLANK_CHAR;
              we_reg    <= 1'b1;
              busy_reg  <= 1'b1;
            end else if (bus.in_data == CR_CHAR) begin
              col_reg   <= 6'd0;
              state_reg <= nl_state;
              row_reg   <= nl_row;
              addr_reg  <= nl_addr;
              we_reg    <= nl_we;
              din_reg   <= nl_din;
              busy_reg  <= nl_busy;
            end else if (bus.in_data == BS_CHAR) begin
              // Backspace at column 0 is a no-op (no move to previous row).
              if (col_reg != 6'd0) begin
                col_reg     <= col_reg - 6'd1;
                addr_reg    <= {row_reg, col_reg - 6'd1};
                din_reg     <= BLANK_CHAR;
                we_reg      <= 1'b1;
                put_adv_reg <= 1'b0;
                state_reg   <= PUT;
              end
            end else begin
              addr_reg    <= {row_reg, col_reg};
              din_reg     <= bus.in_data;
              we_reg      <= 1'b1;
              put_adv_reg <= 1'b1;
              state_reg   <= PUT;
            end
          end
        end

        PUT: begin
          we_reg    <= 1'b0;
          state_reg <= IDLE;
          if (put_adv_reg) begin
            if (col_reg != 6'd63) begin
              col_reg <= col_reg + 6'd1;
            end else begin
              col_reg   <= 6'd0;
              state_reg <= nl_state;
              row_reg   <= nl_row;
              addr_reg  <= nl_addr;
              we_reg    <= nl_we;
              din_reg   <= nl_din;
              busy_reg  <= nl_busy;
            end
          end
        end

`ifdef VRAM_TERM_SCROLL_EN
        // addr_reg holds src in SCROLL_RD and src-64 in SCROLL_WR, so no
        // separate source counter is needed.
        SCROLL_RD: begin
          addr_reg  <= addr_reg - 10'd64;
          we_reg    <= 1'b1;
          state_reg <= SCROLL_WR;
        end

        SCROLL_WR: begin
          if (addr_reg == 10'd959) begin
            // src = 1023 just copied; blank the last row.
            state_reg <= FILL_ROW;
            addr_reg  <= 10'd960;
            din_reg   <= BLANK_CHAR;
            we_reg    <= 1'b1;
          end else begin
            addr_reg  <= addr_reg + 10'd65;
            we_reg    <= 1'b0;
            state_reg <= SCROLL_RD;
          end
        end
`endif

        FILL_ROW: begin
          if (addr_reg[5:0] == 6'd63) begin
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            addr_reg <= addr_reg + 10'd1;
          end
        end

        CLEAR_ALL: begin
          if (addr_reg == 10'd1023) begin
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            col_reg   <= 6'd0;
            row_reg   <= 4'd0;
            state_reg <= IDLE;
          end else begin
            addr_reg <= addr_reg + 10'd1;
          end
        end

        default: begin
          we_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.vram_addr  = addr_reg;
  assign bus.vram_we    = we_reg;
  assign bus.cursor_col = col_reg;
  assign bus.cursor_row = row_reg;
  assign bus.busy       = busy_reg;

`ifdef VRAM_TERM_SCROLL_EN
  // During the copy the RAM read data is written straight back one row up;
  // it only becomes valid in the SCROLL_WR cycle, so it cannot be registered.
  assign bus.vram_din = (state_reg == SCROLL_WR) ? bus.vram_dout : din_reg;
`else
  assign bus.vram_din = din_reg;
  logic unused_dout;
  assign unused_dout = ^bus.vram_dout;
`endif

endmodule
